// File: rtl/colour_sequencer.sv
// Steps the RGB converter's colour code on button edges or an auto-dwell timer, pulses the
// converter enable for one cycle and captures its result into a held output with a valid strobe.
module colour_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               button_i,
  input  logic               auto_mode_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               clear_i,
  output logic [2:0]         colour_o,
  output logic               conv_en_o,
  input  logic [23:0]        rgb_in_i,
  output logic [23:0]        rgb_out_o,
  output logic               rgb_valid_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2:0]         colour_q, colour_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [23:0]        rgb_q, rgb_d;
  logic               valid_q, valid_d;
  logic               button_q;

  logic [DWELL_W-1:0] limit;
  logic               btn_edge;
  logic               auto_expire;
  logic               step;
  logic [2:0]         colour_next;

  // A dwell of zero behaves like one, so the limit bottoms out at zero.
  assign limit       = (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
  assign btn_edge    = button_i & ~button_q;
  assign auto_expire = auto_mode_i & (cnt_q >= limit);
  assign step        = btn_edge | auto_expire;
  assign colour_next = (colour_q == 3'd4) ? 3'd1 : colour_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    colour_d = colour_q;
    cnt_d    = cnt_q;
    rgb_d    = rgb_q;
    valid_d  = 1'b0;
    if (clear_i) begin
      state_d  = StIdle;
      colour_d = 3'd0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        StIdle: begin
          colour_d = 3'd0;
          cnt_d    = '0;
          if (btn_edge || auto_mode_i) begin
            colour_d = 3'd1;
            state_d  = StLoad;
          end
        end
        StLoad: begin
          // Steps seen here are dropped; the edge register still consumes the press.
          rgb_d   = rgb_in_i;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = StHold;
        end
        StHold: begin
          if (step) begin
            colour_d = colour_next;
            cnt_d    = '0;
            state_d  = StLoad;
          end else if (auto_mode_i) begin
            cnt_d = cnt_q + DWELL_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d  = StIdle;
          colour_d = 3'd0;
          cnt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      colour_q <= 3'd0;
      cnt_q    <= '0;
      rgb_q    <= 24'h0;
      valid_q  <= 1'b0;
      button_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      colour_q <= colour_d;
      cnt_q    <= cnt_d;
      rgb_q    <= rgb_d;
      valid_q  <= valid_d;
      button_q <= button_i;
    end
  end

  assign colour_o    = colour_q;
  assign conv_en_o   = (state_q == StLoad);
  assign rgb_out_o   = rgb_q;
  assign rgb_valid_o = valid_q;

endmodule

// File: tb/tb_colour_sequencer.sv
// Directed and randomized checks of colour_sequencer against a cycle-level behavioural model
// that tracks the position in the colour cycle and the run of auto-mode hold cycles.
module tb_colour_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        button = 1'b0;
  logic        auto_mode = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  dwell = 8'd0;
  logic [2:0]  colour;
  logic        conv_en;
  logic [23:0] rgb_in;
  logic [23:0] rgb_out;
  logic        rgb_valid;

  int total = 0;
  int bad = 0;

  colour_sequencer #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button_i   (button),
    .auto_mode_i(auto_mode),
    .dwell_i    (dwell),
    .clear_i    (clear),
    .colour_o   (colour),
    .conv_en_o  (conv_en),
    .rgb_in_i   (rgb_in),
    .rgb_out_o  (rgb_out),
    .rgb_valid_o(rgb_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rgb_of(input logic [2:0] c);
    case (c)
      3'd1:    return 24'hFF0000;
      3'd2:    return 24'hFFA500;
      3'd3:    return 24'h0000FF;
      3'd4:    return 24'h00FF00;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  // Converter stand-in: combinational lookup from the colour code.
  always_comb rgb_in = rgb_of(colour);

  // Behavioural model: position in the four-colour cycle plus a few flags.
  logic [2:0]  ord [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
  bit          m_active, m_load, m_valid, m_bprev;
  int          m_idx, m_run;
  logic [23:0] m_rgb;

  int          cyc, last_chg, nchg, nvalid, nconv;
  int          gaps[$];
  logic [2:0]  prev_col;

  function automatic logic [2:0] exp_col();
    return m_active ? ord[m_idx] : 3'd0;
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] c);
    for (int i = 0; i < 4; i++) if (ord[i] == c) return ord[(i + 1) % 4];
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_load = 0; m_valid = 0; m_bprev = 0;
    m_idx = 0; m_run = 0; m_rgb = 24'h0;
  endtask

  task automatic model_edge();
    bit press = button && !m_bprev;
    int lim = (dwell == 0) ? 0 : int'(dwell) - 1;
    bit expire = auto_mode && (m_run >= lim);
    bit v = 0;
    if (clear) begin
      m_active = 0; m_load = 0; m_run = 0;
    end else if (m_load) begin
      m_rgb = rgb_of(ord[m_idx]); v = 1; m_load = 0; m_run = 0;
    end else if (!m_active) begin
      if (press || auto_mode) begin m_active = 1; m_idx = 0; m_load = 1; end
    end else if (press || expire) begin
      m_idx = (m_idx + 1) % 4; m_load = 1; m_run = 0;
    end else begin
      m_run = auto_mode ? m_run + 1 : 0;
    end
    m_valid = v;
    m_bprev = button;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: advance the model, then compare every output just after the edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check("colour", 32'(colour), 32'(exp_col()));
    check("conv_en", 32'(conv_en), 32'(m_load));
    check("rgb_out", 32'(rgb_out), 32'(m_rgb));
    check("rgb_valid", 32'(rgb_valid), 32'(m_valid));
    if (colour !== prev_col) begin
      gaps.push_back(cyc - last_chg);
      last_chg = cyc;
      nchg++;
    end
    prev_col = colour;
    if (rgb_valid) nvalid++;
    if (conv_en) nconv++;
    @(negedge clk);
  endtask

  task automatic press();
    button = 1'b1;
    tick();
    button = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_colour"}, 32'(colour), 32'd0);
    check({tag, "_conv_en"}, 32'(conv_en), 32'd0);
    check({tag, "_rgb_out"}, 32'(rgb_out), 32'd0);
    check({tag, "_rgb_valid"}, 32'(rgb_valid), 32'd0);
  endtask

  logic [23:0] press_tbl [5] = '{24'hFF0000, 24'hFFA500, 24'h0000FF, 24'h00FF00, 24'hFF0000};
  logic [2:0]  c0;
  int          k;

  initial begin
    cyc = 0; last_chg = 0; nchg = 0; nvalid = 0; nconv = 0; prev_col = 3'd0;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Five manual presses walk the cycle and wrap.
    for (int i = 0; i < 5; i++) begin
      nvalid = 0; nconv = 0;
      press();
      check("press_rgb", 32'(rgb_out), 32'(press_tbl[i]));
      check("press_valid_count", 32'(nvalid), 32'd1);
      check("press_conv_count", 32'(nconv), 32'd1);
    end

    // Auto mode: dwell 3 gives a change every 4 cycles, dwell 0 every 2.
    dwell = 8'd3; auto_mode = 1'b1;
    gaps.delete();
    repeat (18) tick();
    check("auto3_changes", 32'(gaps.size() >= 4), 32'd1);
    for (int i = 1; i < gaps.size(); i++) check("auto3_gap", 32'(gaps[i]), 32'd4);
    dwell = 8'd0;
    gaps.delete();
    repeat (10) tick();
    check("auto0_changes", 32'(gaps.size() >= 4), 32'd1);
    for (int i = 1; i < gaps.size(); i++) check("auto0_gap", 32'(gaps[i]), 32'd2);

    // Press arriving during LOAD is dropped.
    dwell = 8'd5;
    k = 0;
    while (!m_load && k < 20) begin tick(); k++; end
    check("load_reached", 32'(conv_en), 32'd1);
    c0 = colour;
    button = 1'b1; auto_mode = 1'b0;
    tick();
    button = 1'b0;
    repeat (4) tick();
    check("press_in_load", 32'(colour), 32'(c0));

    // Press coincident with auto expiry advances once.
    auto_mode = 1'b1; dwell = 8'd3;
    k = 0;
    while (!(m_active && !m_load && m_run == 2) && k < 20) begin tick(); k++; end
    c0 = colour;
    button = 1'b1;
    tick();
    check("coincident_adv", 32'(colour), 32'(succ(c0)));
    button = 1'b0; auto_mode = 1'b0;
    repeat (3) tick();
    check("coincident_once", 32'(colour), 32'(succ(c0)));

    // Held button steps only once.
    nchg = 0;
    button = 1'b1;
    repeat (20) tick();
    button = 1'b0;
    repeat (2) tick();
    check("held_button", 32'(nchg), 32'd1);

    // Clear from HOLD with blue keeps the captured value.
    k = 0;
    while (colour != 3'd3 && k < 8) begin press(); k++; end
    check("reach_blue", 32'(colour), 32'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_colour", 32'(colour), 32'd0);
    check("clear_rgb_kept", 32'(rgb_out), 32'h0000FF);
    check("clear_valid", 32'(rgb_valid), 32'd0);
    button = 1'b1;
    tick();
    check("after_clear_colour", 32'(colour), 32'd1);
    button = 1'b0;
    tick();
    check("after_clear_rgb", 32'(rgb_out), 32'hFF0000);
    tick();

    // Shrinking dwell below the running count expires on the next edge.
    auto_mode = 1'b1; dwell = 8'd10;
    k = 0;
    while (!(m_active && !m_load && m_run == 5) && k < 30) begin tick(); k++; end
    c0 = colour;
    dwell = 8'd2;
    tick();
    check("dwell_shrink_adv", 32'(colour), 32'(succ(c0)));
    check("dwell_shrink_load", 32'(conv_en), 32'd1);
    auto_mode = 1'b0;
    tick();

    // Randomized traffic against the model.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) button = ~button;
      if ($urandom_range(0, 15) == 0) auto_mode = ~auto_mode;
      dwell = 8'($urandom_range(0, 4));
      clear = ($urandom_range(0, 29) == 0);
      tick();
    end

    // Asynchronous reset in the middle of a LOAD cycle.
    button = 1'b0; auto_mode = 1'b0; clear = 1'b0;
    repeat (2) tick();
    button = 1'b1;
    tick();
    button = 1'b0;
    check("pre_reset_load", 32'(conv_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    check_reset_outputs("held_reset");
    rst_n = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
